// File: rtl/bcd_scan_display.sv
// bcd_scan_display: synchronizes a 4-digit BCD counter chain and its carry/borrow
// pulses, snapshots a coherent frame value and drives a multiplexed, active-low
// 7-segment display with optional leading-zero blanking and sticky OVF/UNF flags.
module bcd_scan_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] QIN,
  input  logic        TCU,
  input  logic        TCD,
  input  logic        BLANK_EN,
  input  logic        CLR_FLAG,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        DP,
  output logic        OVF,
  output logic        UNF
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  logic [15:0]   qin_s1_reg, qin_s2_reg;
  logic          tcu_s1_reg, tcu_s2_reg, tcu_prev_reg;
  logic          tcd_s1_reg, tcd_s2_reg, tcd_prev_reg;
  logic          ovf_reg, unf_reg, ovf_next, unf_next;
  logic [PW-1:0] pre_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   snap_reg;
  logic [6:0]    seg_reg, seg_next;
  logic [3:0]    an_reg, an_next;
  logic          dp_reg, dp_next;
  logic          tcu_fall, tcd_fall, pre_wrap;
  logic [3:0]    digit_zero, blank_mask;
  logic [3:0]    cur_digit;

  // Active-low {g,f,e,d,c,b,a}; codes 10..15 show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  // Two-flop synchronizers plus edge history; pulse lines idle high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      qin_s1_reg   <= '0;
      qin_s2_reg   <= '0;
      tcu_s1_reg   <= 1'b1;
      tcu_s2_reg   <= 1'b1;
      tcu_prev_reg <= 1'b1;
      tcd_s1_reg   <= 1'b1;
      tcd_s2_reg   <= 1'b1;
      tcd_prev_reg <= 1'b1;
    end else begin
      qin_s1_reg   <= QIN;
      qin_s2_reg   <= qin_s1_reg;
      tcu_s1_reg   <= TCU;
      tcu_s2_reg   <= tcu_s1_reg;
      tcu_prev_reg <= tcu_s2_reg;
      tcd_s1_reg   <= TCD;
      tcd_s2_reg   <= tcd_s1_reg;
      tcd_prev_reg <= tcd_s2_reg;
    end
  end

  assign tcu_fall = tcu_prev_reg & ~tcu_s2_reg;
  assign tcd_fall = tcd_prev_reg & ~tcd_s2_reg;
  assign pre_wrap = (pre_reg == PRE_MAX);

  // Sticky flags: a set wins over a simultaneous clear.
  always_comb begin
    ovf_next = ovf_reg;
    unf_next = unf_reg;
    if (CLR_FLAG) begin
      ovf_next = 1'b0;
      unf_next = 1'b0;
    end
    if (tcu_fall) ovf_next = 1'b1;
    if (tcd_fall) unf_next = 1'b1;
  end

  // Flag registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  // Prescaler, digit index and end-of-frame snapshot of the synchronized value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_reg  <= '0;
      idx_reg  <= '0;
      snap_reg <= '0;
    end else begin
      if (pre_wrap) begin
        pre_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
        if (idx_reg == 2'd3) snap_reg <= qin_s2_reg;
      end else begin
        pre_reg <= pre_reg + 1'b1;
      end
    end
  end

  // A digit is blanked when it and every higher digit are zero; digit 0 never is.
  always_comb begin
    for (int i = 0; i < 4; i++) digit_zero[i] = (snap_reg[4*i +: 4] == 4'd0);
    blank_mask[3] = BLANK_EN & digit_zero[3];
    blank_mask[2] = BLANK_EN & digit_zero[3] & digit_zero[2];
    blank_mask[1] = BLANK_EN & digit_zero[3] & digit_zero[2] & digit_zero[1];
    blank_mask[0] = 1'b0;
  end

  // Display drive for the current slot; prescaler 0 is a dark gap against ghosting.
  always_comb begin
    seg_next  = 7'h7F;
    an_next   = 4'hF;
    dp_next   = 1'b1;
    cur_digit = snap_reg[{idx_reg, 2'b00} +: 4];
    if (pre_reg != '0) begin
      an_next  = ~(4'b0001 << idx_reg);
      seg_next = blank_mask[idx_reg] ? 7'h7F : seg_decode(cur_digit);
      dp_next  = ~((idx_reg == 2'd3) & (ovf_reg | unf_reg));
    end
  end

  // Registered display outputs, one cycle behind the scan state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_reg <= 7'h7F;
      an_reg  <= 4'hF;
      dp_reg  <= 1'b1;
    end else begin
      seg_reg <= seg_next;
      an_reg  <= an_next;
      dp_reg  <= dp_next;
    end
  end

  assign SEG = seg_reg;
  assign AN  = an_reg;
  assign DP  = dp_reg;
  assign OVF = ovf_reg;
  assign UNF = unf_reg;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with SCAN_DIV=4.
module tb_bcd_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] qin;
  logic        tcu, tcd, blank_en, clr_flag;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp, ovf, unf;

  int total = 0;
  int bad   = 0;

  bcd_scan_display #(.SCAN_DIV(4)) dut (
    .CLK(clk), .RST_N(rst_n), .QIN(qin), .TCU(tcu), .TCD(tcd),
    .BLANK_EN(blank_en), .CLR_FLAG(clr_flag),
    .SEG(seg), .AN(an), .DP(dp), .OVF(ovf), .UNF(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] qin;
    logic        blank;
    logic [6:0]  seg_exp [4];
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance until AN shows the target pattern, bounded.
  task automatic wait_an(input logic [3:0] target, input string name);
    int n = 0;
    tick();
    while (an !== target && n < 100) begin
      tick();
      n++;
    end
    if (an !== target) begin
      total++;
      bad++;
      $display("FAIL %s: AN never reached %b (last %b)", name, target, an);
    end
  endtask

  initial begin
    logic [3:0] scan_exp [16];
    logic [3:0] sel;

    vecs[0] = '{16'h1987, 1'b0, '{7'h78, 7'h00, 7'h10, 7'h79}};
    vecs[1] = '{16'h0050, 1'b1, '{7'h40, 7'h12, 7'h7F, 7'h7F}};
    vecs[2] = '{16'h0000, 1'b1, '{7'h40, 7'h7F, 7'h7F, 7'h7F}};
    vecs[3] = '{16'h00A0, 1'b0, '{7'h40, 7'h3F, 7'h40, 7'h40}};
    vecs[4] = '{16'h0000, 1'b0, '{7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[5] = '{16'h0203, 1'b1, '{7'h30, 7'h40, 7'h24, 7'h7F}};
    vecs[6] = '{16'h4560, 1'b1, '{7'h40, 7'h02, 7'h12, 7'h19}};
    vecs[7] = '{16'hF00B, 1'b1, '{7'h3F, 7'h40, 7'h40, 7'h3F}};

    for (int k = 0; k < 16; k++)
      scan_exp[k] = (k % 4 == 0) ? 4'hF : ~(4'b0001 << (k / 4));

    rst_n = 1'b0; qin = 16'h0; tcu = 1'b1; tcd = 1'b1;
    blank_en = 1'b0; clr_flag = 1'b0;

    // Reset state and scan order after release.
    repeat (3) tick();
    check("reset_seg", seg, 7'h7F);
    check("reset_an", an, 4'hF);
    check("reset_dp", dp, 1'b1);
    check("reset_ovf", ovf, 1'b0);
    check("reset_unf", unf, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check($sformatf("scan_an[%0d]", k), an, scan_exp[k]);
    end
    $display("scan: 16 AN slots checked");

    // Decode and blanking vectors.
    for (int v = 0; v < 8; v++) begin
      qin = vecs[v].qin;
      blank_en = vecs[v].blank;
      repeat (48) tick();
      for (int d = 0; d < 4; d++) begin
        sel = ~(4'b0001 << d);
        wait_an(sel, $sformatf("vec%0d_d%0d_wait", v, d));
        check($sformatf("vec%0d_d%0d_seg", v, d), seg, vecs[v].seg_exp[d]);
      end
      $display("vector %0d: qin=%h blank=%0d seg=%h/%h/%h/%h", v, vecs[v].qin, vecs[v].blank,
               vecs[v].seg_exp[0], vecs[v].seg_exp[1], vecs[v].seg_exp[2], vecs[v].seg_exp[3]);
    end

    // Overflow pulse latency and decimal point.
    qin = 16'h1987; blank_en = 1'b0;
    repeat (48) tick();
    wait_an(4'b0111, "dp_idle_wait");
    check("dp_idle", dp, 1'b1);
    tcu = 1'b0;
    tick();             // edge n samples TCU low
    tcu = 1'b1;
    tick();             // edge n+1
    check("ovf_n1", ovf, 1'b0);
    tick();             // edge n+2
    check("ovf_n2", ovf, 1'b1);
    check("unf_after_tcu", unf, 1'b0);
    wait_an(4'b0111, "dp_ovf_wait");
    check("dp_ovf_d3", dp, 1'b0);
    wait_an(4'b1110, "dp_d0_wait");
    check("dp_ovf_d0", dp, 1'b1);
    $display("flag: tcu pulse -> ovf=%0d", ovf);

    // Clear.
    clr_flag = 1'b1;
    tick();
    clr_flag = 1'b0;
    check("ovf_clr", ovf, 1'b0);
    $display("flag: clear -> ovf=%0d unf=%0d", ovf, unf);

    // Borrow set coinciding with clear: set wins.
    tcd = 1'b0;
    tick();
    tcd = 1'b1;
    tick();
    check("unf_n1", unf, 1'b0);
    clr_flag = 1'b1;
    tick();
    clr_flag = 1'b0;
    check("unf_set_vs_clr", unf, 1'b1);
    $display("flag: tcd with clear -> unf=%0d", unf);

    // Mid-frame asynchronous reset with OVF set during digit 2.
    tcu = 1'b0;
    tick();
    tcu = 1'b1;
    repeat (2) tick();
    check("ovf_pre_rst", ovf, 1'b1);
    wait_an(4'b1011, "rst_d2_wait");
    #2 rst_n = 1'b0;
    #1;
    check("arst_ovf", ovf, 1'b0);
    check("arst_unf", unf, 1'b0);
    check("arst_an", an, 4'hF);
    check("arst_seg", seg, 7'h7F);
    check("arst_dp", dp, 1'b1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rel_an0", an, 4'hF);
    tick();
    check("rel_an1", an, 4'b1110);
    check("rel_seg_snap0", seg, 7'h40);
    check("rel_ovf", ovf, 1'b0);
    $display("reset: mid-frame reset restarted at digit 0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Downstream display stage for the IC74192 decade up/down counter chain. Consumes four cascaded BCD digits plus the most-significant counter's active-low carry (TCU) and borrow (TCD) pulses. Synchronizes them into the system clock domain, latches a frame snapshot and drives a 4-digit multiplexed, active-low 7-segment display. Latches sticky overflow/underflow flags.

## Interface
Parameters:
- SCAN_DIV, 4: clock cycles per digit slot; legal range 2..65535.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- QIN  in  16  four BCD digits from the counter chain; [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands. Asynchronous to CLK.
- TCU  in  1  active-low carry pulse from the most-significant counter; asynchronous, idles high.
- TCD  in  1  active-low borrow pulse from the most-significant counter; asynchronous, idles high.
- BLANK_EN  in  1  1 = leading-zero blanking enabled; synchronous to CLK.
- CLR_FLAG  in  1  1 = clear OVF/UNF; synchronous to CLK.
- SEG  out  7  active-low segments {g,f,e,d,c,b,a}.
- AN  out  4  active-low digit enables; AN[i] selects digit i.
- DP  out  1  active-low decimal point.
- OVF  out  1  sticky overflow flag.
- UNF  out  1  sticky underflow flag.

## Operation
- Synchronizers:
  - QIN, TCU and TCD each pass through 2 flip-flops.
  - QIN synchronizer flops reset to 0; TCU/TCD synchronizer flops and edge-history flops reset to 1.
- Flags:
  - A 1→0 transition of synchronized TCU sets OVF; the same transition on TCD sets UNF.
  - CLR_FLAG clears both flags. A set and a clear in the same cycle leave the flag set.
- Scan counters:
  - Prescaler runs 0..SCAN_DIV-1 and wraps.
  - Digit index advances 0→1→2→3→0 when the prescaler wraps.
- Snapshot:
  - A 16-bit register loads synchronized QIN on the cycle where index=3 and prescaler=SCAN_DIV-1.
  - Every frame therefore displays one coherent value, with no ripple mixing between digits.
- Anti-ghosting: while prescaler=0, AN=4'b1111 and SEG=7'h7F.
- Digit slot (prescaler ≥ 1):
  - AN has only bit [index] driven low.
  - SEG carries the decode of snapshot digit [index].
- Decode:
  - Digits 0-9 use standard active-low patterns, e.g. 0=7'h40, 1=7'h79, 8=7'h00, 9=7'h10.
  - Codes 10-15 display a dash, 7'h3F.
- Leading-zero blanking:
  - Applies only when BLANK_EN=1.
  - Digit i (i=1..3) is blanked (SEG=7'h7F) when digit i and every higher digit are 0.
  - Digit 0 is never blanked.
- DP is low only during the digit-3 slot with prescaler ≥ 1 and (OVF|UNF)=1; otherwise DP is high.

## Timing
- Reset values:
  - SEG=7'h7F, AN=4'hF, DP=1, OVF=0, UNF=0.
  - Prescaler=0, index=0, snapshot=0.
- Reset is asynchronous: asserting RST_N mid-frame forces all outputs to their reset values immediately, without waiting for a clock edge.
- SEG/AN/DP are registered and lag the prescaler/index state by 1 cycle.
- AN sequence after reset release, per slot: 1 cycle of 4'b1111 followed by SCAN_DIV-1 cycles of the active digit. Frame length is 4*SCAN_DIV cycles.
- Flag latency: TCU first sampled low at edge n makes OVF=1 after edge n+2. TCD/UNF has the same latency.
- A pulse must be low for at least 1 CLK period to be guaranteed detection.
- CLR_FLAG sampled high at edge n makes OVF=UNF=0 after edge n, unless a set occurs at edge n.
- QIN latency: 2 cycles of synchronization, then up to one full frame before the snapshot loads. The new value first appears on digit 0 in the following frame.
- TCU and TCD edges in the same cycle set both OVF and UNF.

## Test plan
- Reset/scan:
  - Stimulus: SCAN_DIV=4, hold RST_N low, then release.
  - Required: SEG=7'h7F and AN=4'hF during reset.
  - Required: AN then cycles 1111,1110×3,1111,1101×3,1111,1011×3,1111,0111×3.
- Decode:
  - Stimulus: QIN=16'h1987, BLANK_EN=0.
  - Required, from the second frame: digit0 SEG=7'h78, digit1 SEG=7'h00, digit2 SEG=7'h10, digit3 SEG=7'h79.
- Blanking:
  - Stimulus: QIN=16'h0050, BLANK_EN=1.
  - Required: digits 3 and 2 SEG=7'h7F, digit1 SEG=7'h12, digit0 SEG=7'h40.
  - Stimulus: QIN=0.
  - Required: only digit0 shows 7'h40.
- Invalid code:
  - Stimulus: QIN=16'h00A0.
  - Required: digit1 SEG=7'h3F.
- Flags:
  - Stimulus: 1-cycle low pulse on TCU.
  - Required: OVF=1 two edges after the pulse is sampled; DP low during the digit-3 slot.
  - Stimulus: CLR_FLAG for 1 cycle.
  - Required: OVF=0.
  - Stimulus: TCD pulse coincident with CLR_FLAG.
  - Required: UNF=1.
- Mid-frame reset:
  - Stimulus: assert RST_N mid-slot with OVF=1, index=2.
  - Required: OVF=0, AN=4'hF and SEG=7'h7F immediately, without a clock edge.
  - Required: after release, scanning restarts at digit 0 with snapshot=0.
